// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the memory access unit.
// Contents: FSM state enum, RISC-V load/store funct3 encodings, byte-size masks,
// and small helpers that decode access size and detect word-boundary crossings.
package mem_access_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_LO   = 3'd1,
    RD_HI   = 3'd2,
    LD_WAIT = 3'd3,
    WR_LO   = 3'd4,
    WR_HI   = 3'd5
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] MASK_B = 32'h0000_00ff;
  localparam logic [31:0] MASK_H = 32'h0000_ffff;
  localparam logic [31:0] MASK_W = 32'hffff_ffff;

  // Access size in bytes (1, 2 or 4); unlisted encodings behave as a word.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    logic [2:0] size;
    case (funct3)
      F3_B, F3_BU: size = 3'd1;
      F3_H, F3_HU: size = 3'd2;
      F3_W:        size = 3'd4;
      default:     size = 3'd4;
    endcase
    return size;
  endfunction

  // True when the access spills into the next word.
  function automatic logic is_split(input logic [1:0] off, input logic [2:0] size);
    return ({1'b0, off} + size) > 3'd4;
  endfunction

  function automatic logic [31:0] size_mask(input logic [2:0] size);
    logic [31:0] mask;
    case (size)
      3'd1:    mask = MASK_B;
      3'd2:    mask = MASK_H;
      default: mask = MASK_W;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Command/response and memory data-port bundle of the memory access unit.
// Signals:
//   cmd_*      : load/store command from the core (valid/ready handshake)
//   resp_*     : one-cycle completion pulse with load result and fault flag
//   mem_*      : word-memory data port (address, write enable, logical-order
//                mask/data out, registered read word in)
// Modports:
//   slave  : the access unit itself
//   master : the environment (core + memory) driving commands and read data
interface mem_access_unit_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [2:0]  cmd_funct3;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_d_addr;
  logic        mem_wen;
  logic [31:0] mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  cmd_valid, cmd_we, cmd_funct3, cmd_addr, cmd_wdata, mem_rdata,
    output cmd_ready, resp_valid, resp_rdata, resp_fault,
    output mem_d_addr, mem_wen, mem_wmask, mem_wdata
  );

  modport master (
    output cmd_valid, cmd_we, cmd_funct3, cmd_addr, cmd_wdata, mem_rdata,
    input  cmd_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_d_addr, mem_wen, mem_wmask, mem_wdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane alignment for the memory access unit (purely combinational).
// Ports:
//   off_i      : byte offset within the word
//   size_i     : access size in bytes (1, 2, 4)
//   unsigned_i : zero-extend sub-word loads when set, else sign-extend
//   st_data_i  : store data, value in the low bytes
//   ld_word_i  : {upper word, lower word} read from memory
//   st_data_o  : store data shifted into position across two words
//   st_mask_o  : byte-enable bit mask shifted the same way
//   ld_data_o  : extracted and extended load result
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [2:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] st_data_i,
  input  logic [63:0] ld_word_i,
  output logic [63:0] st_data_o,
  output logic [63:0] st_mask_o,
  output logic [31:0] ld_data_o
);

  logic [5:0]  shamt;
  logic [31:0] raw;

  always_comb begin
    shamt     = {1'b0, off_i, 3'b000};
    st_data_o = {32'h0, st_data_i} << shamt;
    st_mask_o = {32'h0, size_mask(size_i)} << shamt;
    raw       = 32'(ld_word_i >> shamt);
    case (size_i)
      3'd1:    ld_data_o = {{24{raw[7] & ~unsigned_i}}, raw[7:0]};
      3'd2:    ld_data_o = {{16{raw[15] & ~unsigned_i}}, raw[15:0]};
      default: ld_data_o = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Core-side load/store initiator for the unified word memory data port.
// Accepts one command at a time; word-crossing accesses become two reads
// (merged) or two masked writes. All memory-side and response outputs are
// registered.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus_io   : command/response + memory data port bundle (slave view)
// Build option:
//   MEM_ACCESS_MISALIGN_TRAP_EN : word-crossing accesses issue no memory cycle
//                                 and complete one cycle later with resp_fault.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned WORD_LEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  mem_access_unit_if.slave bus_io
);

  state_e              state_q;
  logic [2:0]          funct3_q;
  logic [WORD_LEN-1:0] addr_q;
  logic [WORD_LEN-1:0] wdata_q;
  logic [WORD_LEN-1:0] lo_q;
  logic [WORD_LEN-1:0] mem_d_addr_q;
  logic [WORD_LEN-1:0] mem_wmask_q;
  logic [WORD_LEN-1:0] mem_wdata_q;
  logic [WORD_LEN-1:0] resp_rdata_q;
  logic                mem_wen_q;
  logic                resp_valid_q;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic                resp_fault_q;
`endif

  logic                  idle;
  logic                  cmd_fire;
  logic [2:0]            sel_funct3;
  logic [WORD_LEN-1:0]   sel_addr;
  logic [WORD_LEN-1:0]   sel_wdata;
  logic [2:0]            size;
  logic [1:0]            off;
  logic                  split;
  logic [WORD_LEN-1:0]   w0;
  logic [WORD_LEN-1:0]   w1;
  logic [2*WORD_LEN-1:0] ld_word;
  logic [2*WORD_LEN-1:0] st_data;
  logic [2*WORD_LEN-1:0] st_mask;
  logic [WORD_LEN-1:0]   ld_data;

  assign idle     = (state_q == IDLE);
  assign cmd_fire = bus_io.cmd_valid && idle;

  // In IDLE the live command feeds the aligner so the first write can be
  // registered on the accept edge; afterwards the latched command is used.
  always_comb begin
    sel_funct3 = idle ? bus_io.cmd_funct3 : funct3_q;
    sel_addr   = idle ? bus_io.cmd_addr   : addr_q;
    sel_wdata  = idle ? bus_io.cmd_wdata  : wdata_q;
    size       = access_size(sel_funct3);
    off        = sel_addr[1:0];
    split      = is_split(off, size);
    w0         = {sel_addr[WORD_LEN-1:2], 2'b00};
    w1         = w0 + WORD_LEN'(4);
    ld_word    = split ? {bus_io.mem_rdata, lo_q} : {{WORD_LEN{1'b0}}, bus_io.mem_rdata};
  end

  mem_lane_align u_align (
    .off_i      (off),
    .size_i     (size),
    .unsigned_i (sel_funct3[2]),
    .st_data_i  (sel_wdata),
    .ld_word_i  (ld_word),
    .st_data_o  (st_data),
    .st_mask_o  (st_mask),
    .ld_data_o  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      funct3_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      lo_q         <= '0;
      mem_d_addr_q <= '0;
      mem_wen_q    <= 1'b0;
      mem_wmask_q  <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      resp_fault_q <= 1'b0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      resp_fault_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (cmd_fire) begin
            funct3_q <= bus_io.cmd_funct3;
            addr_q   <= bus_io.cmd_addr;
            wdata_q  <= bus_io.cmd_wdata;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            // Crossing access: no memory cycle, fault reported from LD_WAIT.
            if (split) begin
              state_q <= LD_WAIT;
            end else
`endif
            if (bus_io.cmd_we) begin
              state_q      <= WR_LO;
              mem_wen_q    <= 1'b1;
              mem_d_addr_q <= w0;
              mem_wdata_q  <= st_data[WORD_LEN-1:0];
              mem_wmask_q  <= st_mask[WORD_LEN-1:0];
            end else begin
              state_q      <= RD_LO;
              mem_d_addr_q <= w0;
            end
          end
        end
        RD_LO: begin
          if (split) begin
            state_q      <= RD_HI;
            mem_d_addr_q <= w1;
          end else begin
            state_q <= LD_WAIT;
          end
        end
        RD_HI: begin
          // Read data for the low word arrives now.
          lo_q    <= bus_io.mem_rdata;
          state_q <= LD_WAIT;
        end
        LD_WAIT: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b1;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
          if (split) begin
            resp_fault_q <= 1'b1;
          end else begin
            resp_rdata_q <= ld_data;
          end
`else
          resp_rdata_q <= ld_data;
`endif
        end
        WR_LO: begin
          if (split) begin
            state_q      <= WR_HI;
            mem_d_addr_q <= w1;
            mem_wdata_q  <= st_data[2*WORD_LEN-1:WORD_LEN];
            mem_wmask_q  <= st_mask[2*WORD_LEN-1:WORD_LEN];
          end else begin
            state_q      <= IDLE;
            mem_wen_q    <= 1'b0;
            resp_valid_q <= 1'b1;
          end
        end
        WR_HI: begin
          state_q      <= IDLE;
          mem_wen_q    <= 1'b0;
          resp_valid_q <= 1'b1;
        end
        default: begin
          state_q   <= IDLE;
          mem_wen_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.cmd_ready  = idle;
  assign bus_io.resp_valid = resp_valid_q;
  assign bus_io.resp_rdata = resp_rdata_q;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign bus_io.resp_fault = resp_fault_q;
`else
  assign bus_io.resp_fault = 1'b0;
`endif
  assign bus_io.mem_d_addr = mem_d_addr_q;
  assign bus_io.mem_wen    = mem_wen_q;
  assign bus_io.mem_wmask  = mem_wmask_q;
  assign bus_io.mem_wdata  = mem_wdata_q;

endmodule
